// File: rtl/dsc_sn_decoder.sv
// dsc_sn_decoder: counts ones of a serial stochastic bitstream over a programmable window.
// Define DSC_DEC_LAST_EN to let sn_last end a conversion before the window limit.
module dsc_sn_decoder #(
  parameter int WXIP1   = 16,
  parameter int MIN_CYC = 256
) (
  input  logic             gclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WXIP1-1:0] cycle_limit,
  input  logic             sn_in,
  input  logic             sn_valid,
  input  logic             sn_last,
  output logic [WXIP1-1:0] bin_out,
  output logic [WXIP1-1:0] cycle_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
`ifdef DSC_DEC_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif
  localparam logic [WXIP1-1:0] L_MIN = WXIP1'(MIN_CYC);
  state_t           r_state;
  logic [WXIP1-1:0] r_limit;
  logic [WXIP1-1:0] w_lim_eff, w_lim_lat, w_cnt_nx;
  logic             w_take, w_end;
  // Zero encodes the longest window, then short windows are raised to the floor.
  assign w_lim_eff = (cycle_limit == '0) ? '1 : cycle_limit;
  assign w_lim_lat = (w_lim_eff < L_MIN) ? L_MIN : w_lim_eff;
  assign w_cnt_nx  = cycle_count + WXIP1'(1);
  assign w_end     = (w_cnt_nx == r_limit) || (LAST_EN && sn_last);
  assign w_take    = start && (r_state == IDLE || (r_state == DONE && out_ready));
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_limit     <= '0;
      bin_out     <= '0;
      cycle_count <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else if (en) begin
      if (w_take) begin
        r_state     <= ACCUM;
        r_limit     <= w_lim_lat;
        bin_out     <= '0;
        cycle_count <= '0;
        overflow    <= 1'b0;
        out_valid   <= 1'b0;
        busy        <= 1'b1;
      end else if (r_state == ACCUM && sn_valid) begin
        cycle_count <= w_cnt_nx;
        if (sn_in && &bin_out) overflow <= 1'b1;
        else if (sn_in) bin_out <= bin_out + WXIP1'(1);
        if (w_end) begin
          r_state   <= DONE;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
      end else if (r_state == DONE && out_ready) begin
        r_state   <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/dsc_sn_decoder.md
# dsc_sn_decoder

Stochastic-to-binary decoder for the DSC datapath. It accepts a serial stochastic-number (SN) bitstream one bit per cycle and counts the ones over a programmable window. It then presents the binary count and the window length to the consumer over a valid/ready handshake. It sits at the output end of the DSC core, converting the product bitstream back to the binary `bin_data_out`/`cycle_count` pair used for accuracy and MAE checks.

## Interface
Parameters:
- `WXIP1`, 16, width of the ones counter, cycle counter and limit.
- `MIN_CYC`, 256, minimum legal window; a latched `cycle_limit` below this is raised to `MIN_CYC`.

Ports:
- `gclk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: global enable; when low, the FSM and all counters hold.
- `start` in 1: begin a conversion; honoured in IDLE, or in DONE together with a completed handshake.
- `cycle_limit` in WXIP1: window length, latched on an accepted `start`; value 0 means 2^WXIP1−1.
- `sn_in` in 1: SN data bit.
- `sn_valid` in 1: `sn_in` is valid this cycle.
- `sn_last` in 1: final bit of the stream (see Configuration).
- `bin_out` out WXIP1: number of ones counted; reset 0.
- `cycle_count` out WXIP1: number of bits accepted; reset 0.
- `out_valid` out 1: result available; reset 0.
- `out_ready` in 1: consumer accepts the result.
- `busy` out 1: high in ACCUM; reset 0.
- `overflow` out 1: sticky per conversion, set if the ones counter saturated; reset 0.

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset state is IDLE.
- IDLE → ACCUM on `en && start`:
  - clear `bin_out`, `cycle_count` and `overflow`;
  - latch `max(cycle_limit_eff, MIN_CYC)`.
- ACCUM, on `en && sn_valid`: the bit is accepted.
  - `cycle_count += 1`.
  - `bin_out += sn_in`, saturating at all-ones; a blocked increment sets `overflow`.
- ACCUM → DONE when the accepted bit makes `cycle_count` equal the latched limit. `bin_out` includes that bit.
- DONE:
  - `out_valid` is high; `bin_out`, `cycle_count` and `overflow` hold.
  - `out_valid && out_ready` with no `start` → IDLE.
  - `out_valid && out_ready && start` → ACCUM directly; counters are cleared and the new limit is latched (back-to-back operation).
- `start` in ACCUM, or in DONE without `out_ready`, is ignored.
- `sn_valid` outside ACCUM is ignored.
- `en` low freezes state, counters and outputs. `out_valid` stays asserted in DONE, but a handshake is not completed while `en` is low.
- `rst_n` low at any time, including mid-conversion or in DONE: all outputs go to their reset values immediately and the FSM returns to IDLE. The partial result is discarded.

## Timing
- Accepted bit at edge k: counters are updated and visible after edge k.
- Latency: the final accepted bit at edge k gives `out_valid` = 1 after edge k. There are no added pipeline stages.
- `busy` falls on the same edge `out_valid` rises.
- Handshake at edge h: `out_valid` = 0 after h, unless a new `start` was taken. In that case `busy` = 1 after h and the first new bit can be accepted at h+1.
- Minimum conversion: 1 start cycle + `MIN_CYC` bit cycles + 1 handshake cycle.
- Counters never wrap:
  - `cycle_count` is bounded by the limit, which is at most 2^WXIP1−1;
  - `bin_out` is bounded by saturation, which is only reachable when the limit equals 2^WXIP1−1.

## Configuration
- `DSC_DEC_LAST_EN` defined:
  - in ACCUM, `en && sn_valid && sn_last` accepts that bit and then → DONE regardless of the limit;
  - `cycle_count` reports the actual window;
  - if `sn_last` coincides with reaching the limit, a single transition to DONE occurs.
- `DSC_DEC_LAST_EN` undefined: `sn_last` is ignored and terminating on the limit is the only exit from ACCUM.

## Test plan
- Reset: assert `rst_n` = 0 → all outputs 0, FSM in IDLE. Release reset, then `start` with `cycle_limit` = 256 and 256 bits of `sn_in` = 1 → `out_valid` after the 256th bit, `bin_out` = 256, `cycle_count` = 256, `overflow` = 0.
- Alternating 1/0 pattern with `cycle_limit` = 300 and `sn_valid` gapped every 3rd cycle → `bin_out` = 150, `cycle_count` = 300.
- `cycle_limit` = 10 → clamped to 256: `cycle_count` = 256 at DONE. `en` dropped for 5 cycles mid-stream → counts unchanged across the gap.
- `out_ready` held low for 20 cycles in DONE → outputs stable, extra `sn_valid`/`start` ignored. Then `out_ready` and `start` together → next conversion starts at once with counters at 0.
- `rst_n` pulsed low after 100 accepted bits → immediate zero outputs and IDLE. A fresh conversion with limit 256 completes with exact counts.
- With `DSC_DEC_LAST_EN`, limit 1000 and `sn_last` on the 400th bit → DONE with `cycle_count` = 400. Without the macro, the same stimulus runs to `cycle_count` = 1000.
